// File: rtl/seg_scan_if.sv
// Write port of the 7-segment scan controller's character buffer.
// The master side drives characters in; the controller is the slave.
interface seg_scan_if #(
  parameter int ADDR_W = 3,
  parameter int CHAR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CHAR_W-1:0] wr_data;
  logic              wr_dp;

  modport master (output wr_en, output wr_addr, output wr_data, output wr_dp);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data, input  wr_dp);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment controller with a writable per-digit buffer.
// Optional per-digit PWM brightness is enabled with the macro SEG_SCAN_BRIGHTNESS_EN.
module seg_scan_ctrl #(
  parameter int NUM_DIG = 8,
  parameter int ADDR_W  = 3,
  parameter int PRESC_W = 15,
  parameter int CHAR_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
`ifdef SEG_SCAN_BRIGHTNESS_EN
  input  logic [3:0]         bright,
`endif
  seg_scan_if.slave          wr,
  output logic [7:0]         seg,
  output logic [NUM_DIG-1:0] dig
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [CHAR_W-1:0] BLANK = CHAR_W'(5'h10);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_DIG - 1);

  // Active-low g..a pattern; unlisted codes show blank.
  function automatic logic [6:0] decode(input logic [CHAR_W-1:0] code);
    logic [31:0] c;
    c = 32'(code);
    case (c)
      32'h00:  decode = 7'b1000000;
      32'h01:  decode = 7'b1111001;
      32'h02:  decode = 7'b0100100;
      32'h03:  decode = 7'b0110000;
      32'h04:  decode = 7'b0011001;
      32'h05:  decode = 7'b0010010;
      32'h06:  decode = 7'b0000010;
      32'h07:  decode = 7'b1111000;
      32'h08:  decode = 7'b0000000;
      32'h09:  decode = 7'b0010000;
      32'h0A:  decode = 7'b0001000;
      32'h0B:  decode = 7'b0000011;
      32'h0C:  decode = 7'b1000110;
      32'h0D:  decode = 7'b0100001;
      32'h0E:  decode = 7'b0000110;
      32'h0F:  decode = 7'b0001110;
      32'h11:  decode = 7'b0001100;
      32'h12:  decode = 7'b0101111;
      32'h13:  decode = 7'b0001001;
      32'h14:  decode = 7'b1000111;
      32'h15:  decode = 7'b0111111;
      default: decode = 7'b1111111;
    endcase
  endfunction

  logic [PRESC_W-1:0] presc_r;
  logic [ADDR_W-1:0]  idx_r;
  logic [CHAR_W:0]    char_buf_r [DEPTH];
  logic [7:0]         seg_r;
  logic [NUM_DIG-1:0] dig_r;

  logic               tick_s;
  logic               lit_s;
  logic               wr_ok_s;
  logic [CHAR_W:0]    cur_s;
  logic [7:0]         seg_nxt_s;
  logic [NUM_DIG-1:0] dig_nxt_s;
`ifdef SEG_SCAN_BRIGHTNESS_EN
  logic [PRESC_W-1:0] presc_nxt_s;
`endif

  // Next-output computation from the current index, buffer and enable.
  always_comb begin
    tick_s    = &presc_r;
    wr_ok_s   = wr.wr_en && (32'(wr.wr_addr) < NUM_DIG);
    cur_s     = char_buf_r[idx_r];
    lit_s     = !tick_s;
    seg_nxt_s = 8'hFF;
    dig_nxt_s = '1;
`ifdef SEG_SCAN_BRIGHTNESS_EN
    // Duty window is judged on the prescaler value seen while the output is shown.
    presc_nxt_s = presc_r + PRESC_W'(1);
    lit_s       = !tick_s && (presc_nxt_s[PRESC_W-1 -: 4] <= bright);
`endif
    if (en) begin
      seg_nxt_s = {~cur_s[CHAR_W], decode(cur_s[CHAR_W-1:0])};
      if (lit_s) begin
        dig_nxt_s = ~(NUM_DIG'(1) << idx_r);
      end else begin
        dig_nxt_s = '1;
      end
    end else begin
      seg_nxt_s = 8'hFF;
      dig_nxt_s = '1;
    end
  end

  // Prescaler, scan index, character buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= '0;
      idx_r   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        char_buf_r[i] <= {1'b0, BLANK};
      end
      seg_r   <= 8'hFF;
      dig_r   <= '1;
    end else begin
      presc_r <= presc_r + PRESC_W'(1);
      if (tick_s) begin
        idx_r <= (idx_r == LAST) ? '0 : idx_r + ADDR_W'(1);
      end
      if (wr_ok_s) begin
        char_buf_r[wr.wr_addr] <= {wr.wr_dp, wr.wr_data};
      end
      seg_r   <= seg_nxt_s;
      dig_r   <= dig_nxt_s;
    end
  end

  assign seg = seg_r;
  assign dig = dig_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: an 8-digit and a 6-digit instance share one write port.
module tb_seg_scan_ctrl;

  localparam int PRESC = 2;
  localparam int DWELL = 1 << PRESC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [7:0] seg8, seg6;
  logic [7:0] dig8;
  logic [5:0] dig6;

  seg_scan_if #(.ADDR_W(3), .CHAR_W(5)) wif ();

  seg_scan_ctrl #(.NUM_DIG(8), .ADDR_W(3), .PRESC_W(PRESC), .CHAR_W(5)) u8 (
    .clk(clk), .rst(rst), .en(en), .wr(wif.slave), .seg(seg8), .dig(dig8));

  seg_scan_ctrl #(.NUM_DIG(6), .ADDR_W(3), .PRESC_W(PRESC), .CHAR_W(5)) u6 (
    .clk(clk), .rst(rst), .en(en), .wr(wif.slave), .seg(seg6), .dig(dig6));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s8;
    logic [7:0] d8;
    logic [7:0] s6;
    logic [5:0] d6;
    bit         c8;
    bit         c6;
  } exp_t;

  exp_t       q[$];
  logic [6:0] dec_tab [32];
  logic [5:0] mbuf [2][8];
  int         edges [2];
  int         checks = 0;
  int         errors = 0;

  initial begin
    for (int i = 0; i < 32; i++) dec_tab[i] = 7'b1111111;
    dec_tab[0]  = 7'b1000000; dec_tab[1]  = 7'b1111001; dec_tab[2]  = 7'b0100100;
    dec_tab[3]  = 7'b0110000; dec_tab[4]  = 7'b0011001; dec_tab[5]  = 7'b0010010;
    dec_tab[6]  = 7'b0000010; dec_tab[7]  = 7'b1111000; dec_tab[8]  = 7'b0000000;
    dec_tab[9]  = 7'b0010000; dec_tab[10] = 7'b0001000; dec_tab[11] = 7'b0000011;
    dec_tab[12] = 7'b1000110; dec_tab[13] = 7'b0100001; dec_tab[14] = 7'b0000110;
    dec_tab[15] = 7'b0001110; dec_tab[17] = 7'b0001100; dec_tab[18] = 7'b0101111;
    dec_tab[19] = 7'b0001001; dec_tab[20] = 7'b1000111; dec_tab[21] = 7'b0111111;
  end

  // Reference model: digit and dwell phase follow from the number of edges since reset.
  always @(posedge clk) begin
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      int         n;
      int         p;
      int         ix;
      logic [7:0] s;
      logic [7:0] d;
      bit         c;
      n = (i == 0) ? 8 : 6;
      if (rst) begin
        s = 8'hFF; d = 8'hFF; c = 1'b1;
        edges[i] = 0;
        for (int j = 0; j < 8; j++) mbuf[i][j] = 6'h10;
      end else begin
        p  = edges[i] % DWELL;
        ix = (edges[i] / DWELL) % n;
        if (!en) begin
          s = 8'hFF; d = 8'hFF; c = 1'b1;
        end else begin
          s = {~mbuf[i][ix][5], dec_tab[mbuf[i][ix][4:0]]};
          d = (p == DWELL - 1) ? 8'hFF : ~(8'h01 << ix);
          c = (p != DWELL - 1);
        end
        edges[i] = edges[i] + 1;
        if (wif.wr_en && (int'(wif.wr_addr) < n)) mbuf[i][wif.wr_addr] = {wif.wr_dp, wif.wr_data};
      end
      if (i == 0) begin
        x.s8 = s; x.d8 = d; x.c8 = c;
      end else begin
        x.s6 = s; x.d6 = d[5:0]; x.c6 = c;
      end
    end
    q.push_back(x);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expectation per clock, compared away from the active edge.
  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("dig8", dig8, x.d8);
      chk("dig6", {2'b00, dig6}, {2'b00, x.d6});
      if (x.c8) chk("seg8", seg8, x.s8);
      if (x.c6) chk("seg6", seg6, x.s6);
    end
  end

  task automatic wr(input int a, input int d, input bit dp);
    wif.wr_en   = 1'b1;
    wif.wr_addr = 3'(a);
    wif.wr_data = 5'(d);
    wif.wr_dp   = dp;
    @(negedge clk);
    wif.wr_en   = 1'b0;
  endtask

  initial begin
    int codes [8];
    codes = '{12, 17, 14, 1, 6, 6, 10, 18};
    wif.wr_en = 1'b0; wif.wr_addr = 3'd0; wif.wr_data = 5'd0; wif.wr_dp = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    for (int a = 0; a < 8; a++) wr(a, codes[a], a == 3);
    repeat (70) @(negedge clk);
    wr(2, 8, 1'b0);
    repeat (20) @(negedge clk);
    wr(6, 3, 1'b1);
    wr(7, 21, 1'b0);
    repeat (40) @(negedge clk);
    en = 1'b0;
    repeat (7) @(negedge clk);
    en = 1'b1;
    repeat (30) @(negedge clk);
    for (int k = 0; k < 500; k++) begin
      en          = ($urandom_range(0, 9) != 0);
      wif.wr_en   = ($urandom_range(0, 3) == 0);
      wif.wr_addr = 3'($urandom_range(0, 7));
      wif.wr_data = 5'($urandom_range(0, 31));
      wif.wr_dp   = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    wif.wr_en = 1'b0;
    en = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    repeat (2) @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Parametrised, time-multiplexed 7-segment display controller. It drives NUM_DIG common-anode digits, one at a time, from a writable per-digit character buffer. It replaces the fixed-message scanner: characters are loaded at run time through a simple write port, and each digit has its own decimal point. The block sits between application logic (status or counter display) and the board's seg/dig pins.

Parameters:
NUM_DIG, 8, number of digits scanned (2..16)
ADDR_W, 3, write address width; must satisfy 2^ADDR_W >= NUM_DIG
PRESC_W, 15, prescaler width; each digit is active for 2^PRESC_W clocks
CHAR_W, 5, character code width

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
en  input  1  display enable; 0 blanks all digits
wr_en  input  1  buffer write strobe, sampled on clk rising edge
wr_addr  input  ADDR_W  digit to write; 0 = rightmost (dig[0])
wr_data  input  CHAR_W  character code
wr_dp  input  1  decimal point for the written digit, 1 = lit
seg  output  8  segments, active-low; seg[7] = dp, seg[6:0] = g..a
dig  output  NUM_DIG  digit anodes, active-low, one-hot-low while scanning

Behaviour:
- One clock domain. Reset is synchronous, active-high, and has priority over everything else.
- Reset state: prescaler = 0; scan index = 0; every buffer entry = code 0x10 (blank) with dp = 0; seg = 8'hFF; dig = all ones.
- Prescaler: free-running PRESC_W-bit up counter that wraps to 0. Its terminal count (all ones) is the "tick".
- Scan index: on tick, the index increments; NUM_DIG-1 wraps to 0. For non-power-of-2 NUM_DIG, the index never exceeds NUM_DIG-1.
- Outputs are registered, with 1-cycle latency from the index and buffer values.
  - dig = ~(1 << idx).
  - seg[6:0] = decode(buf[idx]).
  - seg[7] = ~dp[idx].
- Dead time: on the cycle immediately after a tick, dig is forced to all ones for exactly 1 clock (anti-ghosting). seg is updated during that cycle.
- en = 0: dig = all ones and seg = 8'hFF from the next edge. Prescaler and index keep running. Buffer writes are still accepted.
- Write: when wr_en = 1 and wr_addr < NUM_DIG, buf[wr_addr] <= {wr_dp, wr_data} on that edge.
  - wr_addr >= NUM_DIG: the write is ignored and no entry changes.
  - Write to the digit currently scanned: seg shows the new value 1 clock after the write edge.
  - A write on a tick cycle is processed normally; the write and the index advance are independent.
- Decode table (seg[6:0], active-low g..a):
  - Hex digits:
    - 0x00 '0' 1000000
    - 0x01 '1' 1111001
    - 0x02 '2' 0100100
    - 0x03 '3' 0110000
    - 0x04 '4' 0011001
    - 0x05 '5' 0010010
    - 0x06 '6' 0000010
    - 0x07 '7' 1111000
    - 0x08 '8' 0000000
    - 0x09 '9' 0010000
    - 0x0A 'A' 0001000
    - 0x0B 'b' 0000011
    - 0x0C 'C' 1000110
    - 0x0D 'd' 0100001
    - 0x0E 'E' 0000110
    - 0x0F 'F' 0001110
  - Extra characters:
    - 0x10 blank 1111111
    - 0x11 'P' 0001100
    - 0x12 'r' 0101111
    - 0x13 'H' 0001001
    - 0x14 'L' 1000111
    - 0x15 '-' 0111111
  - All other codes decode to blank.
- Reset asserted mid-scan: the next edge returns the block to the reset state, and the buffer contents are lost.

Optional Feature:
Macro: SEG_SCAN_BRIGHTNESS_EN.
- Defined:
  - Adds input port bright (4 bits).
  - Within each digit's dwell, the anode is asserted only while prescaler[PRESC_W-1:PRESC_W-4] <= bright.
  - bright = 15 gives full duty (minus dead time); bright = 0 gives 1/16 duty.
  - seg is unaffected.
  - bright is sampled every cycle, so a change takes effect within the current dwell.
- Not defined: no bright port; the anode is asserted for the full dwell minus dead time.

Test Plan:
1. Reset/idle (PRESC_W=2, NUM_DIG=8): hold rst 3 clocks, then release with en = 1.
   - seg = 8'hFF during reset and dig = 8'hFF during reset.
   - Afterwards, dig steps FE, FD, FB, ... 7F, FE, with a 4-clock period per digit, dead-time cycle = FF.
   - seg stays 8'hFF (all entries blank).
2. Write/decode: write addr 0..7 = 0x0C, 0x11, 0x0E, 0x01, 0x06, 0x06, 0x0A, 0x12, with dp = 1 on addr 3.
   - While dig = FE, seg = 8'hC6; while dig = F7, seg = 8'h79 (dp lit); while dig = 7F, seg = 8'hAF.
3. Live update: write 0x08 to addr 2 while dig = FB.
   - seg changes to 8'h80 exactly 1 clock after the write edge.
4. Boundaries with NUM_DIG=6: idx wraps 5 -> 0, so dig = 3E follows 1F, with no 3F state other than dead time. A write to addr 6 or 7 leaves every digit unchanged.
5. Enable/reset mid-operation: en = 0 gives dig = all ones and seg = FF on the next edge; on en = 1, scanning resumes at the running index. Asserting rst for 1 clock mid-dwell gives dig = FF, seg = FF, and the buffer reads blank afterwards.
6. With SEG_SCAN_BRIGHTNESS_EN defined and PRESC_W=6: bright = 3 asserts the anode for 15 of 64 dwell cycles (16 minus 1 dead); bright = 15 asserts it for 63 of 64.
